// File: rtl/masked_event_splice.sv
// Per-SURF event splicer: frames raw SURF bytes into fixed-length events, or synthesises
// fake events per trigger while masked, and queues them into an AXI4-Stream FWFT FIFO.
module masked_event_splice #(
    parameter int unsigned NCHAN          = 8,
    parameter int unsigned CH_BYTES       = 1536,
    parameter int unsigned HDR_BYTES      = 4,
    parameter int unsigned FIFO_DEPTH     = 2048,
    parameter int unsigned TRIG_CNT_WIDTH = 4,
    parameter int unsigned FILL_MODE      = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        trig_i,
    input  logic        mask_i,
    input  logic        mask_ce_i,
    input  logic [7:0]  s_dout_tdata,
    input  logic        s_dout_tvalid,
    output logic [7:0]  m_dout_tdata,
    output logic        m_dout_tvalid,
    input  logic        m_dout_tready,
    output logic        m_dout_tlast,
    output logic        m_dout_tuser,
    output logic [2:0]  err_o,
    output logic [15:0] event_cnt_o
);

    localparam int unsigned EVENT_BYTES = HDR_BYTES + NCHAN * CH_BYTES;
    localparam int unsigned BCW         = $clog2(EVENT_BYTES);
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(EVENT_BYTES - 1);
    localparam logic [BCW-1:0] HDR_IDX  = BCW'(HDR_BYTES);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                    state;
    logic                      eff_mask;
    logic [BCW-1:0]            byte_idx;
    logic [TRIG_CNT_WIDTH-1:0] trig_cnt;
    logic                      err_ovf, err_sat, err_stray;

    // Single register stage between framing and the FIFO
    logic       st_valid, st_last, st_user;
    logic [7:0] st_data;

    logic       real_start_c, fake_start_c, stray_c, cnt_wr_c, wr_last_c;
    logic [7:0] fake_byte_c;

    always_comb begin
        real_start_c = (state == IDLE) && !mask_i && s_dout_tvalid && s_dout_tdata[7];
        stray_c      = (state == IDLE) && !mask_i && s_dout_tvalid && !s_dout_tdata[7];
        fake_start_c = (state == IDLE) && mask_i && (trig_cnt != '0);
        cnt_wr_c     = (state == COUNT) && (eff_mask ? mask_ce_i : s_dout_tvalid);
        wr_last_c    = (byte_idx == LAST_IDX);
        fake_byte_c  = 8'h00;
        if ((byte_idx >= HDR_IDX) && (FILL_MODE != 0))
            fake_byte_c = 8'(byte_idx);
    end

    // Framing FSM; mask is latched in IDLE and held for the whole event
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            eff_mask  <= 1'b0;
            byte_idx  <= '0;
            err_stray <= 1'b0;
            st_valid  <= 1'b0;
            st_last   <= 1'b0;
            st_user   <= 1'b0;
            st_data   <= 8'h00;
        end else begin
            st_valid <= 1'b0;
            st_last  <= 1'b0;
            case (state)
                IDLE: begin
                    eff_mask <= mask_i;
                    byte_idx <= '0;
                    if (stray_c)
                        err_stray <= 1'b1;
                    if (real_start_c) begin
                        st_valid <= 1'b1;
                        st_data  <= s_dout_tdata;
                        st_user  <= 1'b0;
                        byte_idx <= BCW'(1);
                        state    <= COUNT;
                    end else if (fake_start_c) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (cnt_wr_c) begin
                        st_valid <= 1'b1;
                        st_data  <= eff_mask ? fake_byte_c : s_dout_tdata;
                        st_user  <= eff_mask;
                        st_last  <= wr_last_c;
                        if (wr_last_c) begin
                            byte_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + BCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending-trigger counter, only meaningful while masked
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            trig_cnt <= '0;
            err_sat  <= 1'b0;
        end else if (!mask_i) begin
            trig_cnt <= '0;
        end else if (trig_i && !fake_start_c) begin
            if (trig_cnt == '1)
                err_sat <= 1'b1;
            else
                trig_cnt <= trig_cnt + TRIG_CNT_WIDTH'(1);
        end else if (!trig_i && fake_start_c) begin
            trig_cnt <= trig_cnt - TRIG_CNT_WIDTH'(1);
        end
    end

    // Output FIFO, first-word-fall-through; entry = {tuser, tlast, tdata}
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt_c;
    logic          full_c, wr_en_c, rd_en_c;
    logic [9:0]    rd_word;

    always_comb begin
        full_c      = (count == (AW + 1)'(FIFO_DEPTH));
        wr_en_c     = st_valid && !full_c;
        rd_en_c     = m_dout_tvalid && m_dout_tready;
        count_nxt_c = count + (AW + 1)'(wr_en_c) - (AW + 1)'(rd_en_c);
    end

    always_ff @(posedge aclk) begin
        if (wr_en_c)
            mem[wr_ptr] <= {st_user, st_last, st_data};
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            m_dout_tvalid <= 1'b0;
            err_ovf       <= 1'b0;
            event_cnt_o   <= 16'h0000;
        end else begin
            if (wr_en_c)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en_c)
                rd_ptr <= rd_ptr + AW'(1);
            count         <= count_nxt_c;
            m_dout_tvalid <= (count_nxt_c != '0);
            if (st_valid && full_c)
                err_ovf <= 1'b1;
            if (wr_en_c && st_last)
                event_cnt_o <= event_cnt_o + 16'd1;
        end
    end

    assign rd_word      = mem[rd_ptr];
    assign m_dout_tdata = rd_word[7:0];
    assign m_dout_tlast = m_dout_tvalid & rd_word[8];
    assign m_dout_tuser = m_dout_tvalid & rd_word[9];
    assign err_o        = {err_stray, err_sat, err_ovf};

endmodule

// File: tb/tb_masked_event_splice.sv
// Self-checking bench for masked_event_splice (12-byte events, 16-byte FIFO): directed
// vector table, multi-cycle corner sequences, and a randomized run against an event-level model.
`timescale 1ns/1ps
module tb_masked_event_splice;

    localparam int unsigned EB = 12;
    localparam int unsigned HB = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        trig_i = 1'b0;
    logic        mask_i = 1'b0;
    logic        mask_ce_i = 1'b0;
    logic [7:0]  s_dout_tdata = 8'h00;
    logic        s_dout_tvalid = 1'b0;
    logic [7:0]  m_dout_tdata;
    logic        m_dout_tvalid;
    logic        m_dout_tready = 1'b1;
    logic        m_dout_tlast;
    logic        m_dout_tuser;
    logic [2:0]  err_o;
    logic [15:0] event_cnt_o;

    masked_event_splice #(
        .NCHAN(2), .CH_BYTES(4), .HDR_BYTES(4), .FIFO_DEPTH(16),
        .TRIG_CNT_WIDTH(4), .FILL_MODE(1)
    ) dut (
        .aclk(aclk), .areset(areset), .trig_i(trig_i), .mask_i(mask_i), .mask_ce_i(mask_ce_i),
        .s_dout_tdata(s_dout_tdata), .s_dout_tvalid(s_dout_tvalid),
        .m_dout_tdata(m_dout_tdata), .m_dout_tvalid(m_dout_tvalid), .m_dout_tready(m_dout_tready),
        .m_dout_tlast(m_dout_tlast), .m_dout_tuser(m_dout_tuser),
        .err_o(err_o), .event_cnt_o(event_cnt_o)
    );

    always #5 aclk = ~aclk;

    typedef logic [9:0] obyte_t;   // {tuser, tlast, tdata}

    obyte_t got_q[$];
    obyte_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     ce_mode = 0;           // 0 off, 1 every 3rd cycle, 2 random, 3 every cycle
    int     ce_ph = 0;
    bit     rdy_rand = 1'b0;
    bit     rdy_level = 1'b1;

    // Output monitor: handshake sampled mid-cycle
    always @(negedge aclk)
        if (!areset && m_dout_tvalid && m_dout_tready)
            got_q.push_back({m_dout_tuser, m_dout_tlast, m_dout_tdata});

    // Pacing strobe and sink ready generator
    always @(posedge aclk) begin
        #1;
        case (ce_mode)
            1: begin ce_ph = (ce_ph + 1) % 3; mask_ce_i = (ce_ph == 0); end
            2: mask_ce_i = ($urandom_range(0, 2) == 0);
            3: mask_ce_i = 1'b1;
            default: mask_ce_i = 1'b0;
        endcase
        m_dout_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_level;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic obyte_t mk(input bit u, input int i, input logic [7:0] d);
        return {u, (i == EB - 1), d};
    endfunction

    function automatic obyte_t fake_byte(input int i);
        return mk(1'b1, i, (i < HB) ? 8'h00 : 8'(i));
    endfunction

    task automatic do_reset();
        areset = 1'b1;
        mask_i = 1'b0; trig_i = 1'b0; s_dout_tvalid = 1'b0; s_dout_tdata = 8'h00;
        ce_mode = 0; rdy_rand = 1'b0; rdy_level = 1'b1;
        repeat (2) tick();
        areset = 1'b0;
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] d);
        s_dout_tdata = d;
        s_dout_tvalid = 1'b1;
        tick();
        s_dout_tvalid = 1'b0;
    endtask

    // One real event: header then payload (index values, or random when rnd)
    task automatic send_event(input logic [7:0] hdr, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < int'(EB); i++) begin
            b = (i == 0) ? hdr : (rnd ? 8'($urandom) : 8'(i));
            exp_q.push_back(mk(1'b0, i, b));
            send_byte(b);
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            else tick();
        end
    endtask

    task automatic wait_bytes(input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        repeat (4) tick();
        check({nm, "_count"}, 32'(got_q.size()), 32'(n));
    endtask

    typedef struct {
        bit         fake;
        logic [7:0] hdr0;
        bit         stray;
        logic [2:0] exp_err;
        bit         exp_user;
        logic [7:0] exp_b0;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] eb;
    int         k, nev, base, w;
    bit         any_stray;

    initial begin
        vecs[0] = '{1'b0, 8'h85, 1'b0, 3'b000, 1'b0, 8'h85};
        vecs[1] = '{1'b0, 8'hFF, 1'b1, 3'b100, 1'b0, 8'hFF};
        vecs[2] = '{1'b0, 8'h80, 1'b0, 3'b000, 1'b0, 8'h80};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 3'b000, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 3'b000, 1'b1, 8'h00};

        // Reset state, checked while reset is held and just after release
        #2;
        check("rst_tvalid", 32'(m_dout_tvalid), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        do_reset();
        check("rst_tlast_tuser", 32'({m_dout_tlast, m_dout_tuser}), 32'd0);
        check("rst_evcnt", 32'(event_cnt_o), 32'd0);
        check("rst_tvalid_post", 32'(m_dout_tvalid), 32'd0);

        // Table-driven single events
        for (int v = 0; v < 5; v++) begin
            do_reset();
            mask_i = vecs[v].fake;
            tick();
            if (vecs[v].stray) begin send_byte(8'h12); tick(); end
            if (vecs[v].fake) begin
                ce_mode = 1;
                trig_i = 1'b1; tick(); trig_i = 1'b0;
            end else begin
                send_event(vecs[v].hdr0, 1'b0);
            end
            wait_bytes(EB, 300, $sformatf("v%0d", v));
            for (int i = 0; i < int'(EB) && i < got_q.size(); i++) begin
                eb = (i == 0) ? vecs[v].exp_b0 : ((vecs[v].exp_user && i < int'(HB)) ? 8'h00 : 8'(i));
                check($sformatf("v%0d_byte%0d", v, i), 32'(got_q[i]), 32'(mk(vecs[v].exp_user, i, eb)));
            end
            check($sformatf("v%0d_err", v), 32'(err_o), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_evcnt", v), 32'(event_cnt_o), 32'd1);
            mask_i = 1'b0;
            ce_mode = 0;
        end

        // Two fake events paced every third cycle
        do_reset();
        mask_i = 1'b1; tick();
        ce_mode = 1;
        trig_i = 1'b1; tick(); trig_i = 1'b0; tick();
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        wait_bytes(2 * EB, 400, "fake2");
        for (int i = 0; i < 2 * int'(EB) && i < got_q.size(); i++)
            check($sformatf("fake2_byte%0d", i), 32'(got_q[i]), 32'(fake_byte(i % int'(EB))));
        check("fake2_evcnt", 32'(event_cnt_o), 32'd2);
        check("fake2_err", 32'(err_o), 32'd0);

        // Mask rises mid real event: that event stays real, next one is fake
        do_reset();
        ce_mode = 1;
        for (int i = 0; i < int'(EB); i++) begin
            if (i == 5) begin mask_i = 1'b1; trig_i = 1'b1; end
            send_byte((i == 0) ? 8'h85 : 8'(i));
            trig_i = 1'b0;
            tick();
        end
        wait_bytes(2 * EB, 400, "midmask");
        for (int i = 0; i < 2 * int'(EB) && i < got_q.size(); i++)
            check($sformatf("midmask_byte%0d", i), 32'(got_q[i]),
                  32'((i < int'(EB)) ? mk(1'b0, i, (i == 0) ? 8'h85 : 8'(i)) : fake_byte(i - int'(EB))));
        mask_i = 1'b0;
        ce_mode = 0;

        // Backpressure through two events: 16 stored, 8 dropped
        do_reset();
        rdy_level = 1'b0;
        tick();
        send_event(8'h85, 1'b0);
        send_event(8'h85, 1'b0);
        repeat (5) tick();
        check("bp_err", 32'(err_o), 32'b001);
        check("bp_evcnt", 32'(event_cnt_o), 32'd1);
        check("bp_held", 32'(got_q.size()), 32'd0);
        rdy_level = 1'b1;
        wait_bytes(16, 100, "bp");
        if (got_q.size() >= 16) begin
            check("bp_b11", 32'(got_q[11]), 32'(mk(1'b0, 11, 8'h0B)));
            check("bp_b12", 32'(got_q[12]), 32'(mk(1'b0, 0, 8'h85)));
            check("bp_b15", 32'(got_q[15]), 32'(mk(1'b0, 3, 8'h03)));
        end

        // Trigger counter saturation: 1 started + 15 pending = 16 fake events
        do_reset();
        mask_i = 1'b1; tick();
        trig_i = 1'b1;
        repeat (20) tick();
        trig_i = 1'b0;
        tick();
        check("sat_err", 32'(err_o), 32'b010);
        ce_mode = 3;
        wait_bytes(16 * EB, 3000, "sat");
        check("sat_evcnt", 32'(event_cnt_o), 32'd16);
        check("sat_err_end", 32'(err_o), 32'b010);
        mask_i = 1'b0;
        ce_mode = 0;

        // Reset in the middle of an event
        do_reset();
        send_byte(8'h12);
        send_byte(8'h85);
        for (int i = 1; i < 4; i++) send_byte(8'(i));
        areset = 1'b1;
        #2;
        check("midrst_tvalid", 32'(m_dout_tvalid), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        check("midrst_evcnt", 32'(event_cnt_o), 32'd0);
        tick(); tick();
        areset = 1'b0;
        tick();
        got_q.delete();
        exp_q.delete();
        send_event(8'h85, 1'b0);
        wait_bytes(EB, 300, "midrst");
        for (int i = 0; i < int'(EB) && i < got_q.size(); i++)
            check($sformatf("midrst_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        // Randomized mix of real and fake events against an event-level model
        do_reset();
        rdy_rand = 1'b1;
        any_stray = 1'b0;
        nev = 0;
        for (int s = 0; s < 40; s++) begin
            base = exp_q.size();
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) send_byte(8'($urandom_range(0, 127)));
                    any_stray = 1'b1;
                end
                send_event(8'($urandom_range(128, 255)), 1'b1);
                nev++;
            end else begin
                k = $urandom_range(1, 3);
                mask_i = 1'b1;
                tick();
                ce_mode = 2;
                for (int j = 0; j < k; j++) begin
                    trig_i = 1'b1; tick(); trig_i = 1'b0;
                    repeat ($urandom_range(0, 3)) tick();
                end
                for (int j = 0; j < k * int'(EB); j++) exp_q.push_back(fake_byte(j % int'(EB)));
                nev += k;
                w = 0;
                while (got_q.size() < exp_q.size() && w < 3000) begin
                    s_dout_tvalid = 1'($urandom_range(0, 1));
                    s_dout_tdata = 8'($urandom);
                    tick();
                    w++;
                end
                s_dout_tvalid = 1'b0;
                ce_mode = 0;
                tick();
                mask_i = 1'b0;
                tick();
            end
            wait_bytes(exp_q.size(), 2000, $sformatf("rnd%0d", s));
            for (int i = base; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("rnd%0d_byte%0d", s, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("rnd_err", 32'(err_o), 32'({any_stray, 2'b00}));
        check("rnd_evcnt", 32'(event_cnt_o), 32'(nev));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
